// File: rtl/bq_pkg.sv
// Shared definitions for the biquad sample feeder: sample width, register map,
// CTRL/STATUS bit positions and the bus handshake state type.
package bq_pkg;

  localparam int BQ_DW = 12;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_MASK    = 2;
  localparam int CTRL_DIV_LSB = 16;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UDF     = 3;
  localparam int STAT_LVL_LSB = 8;

  typedef logic [BQ_DW-1:0] sample_t;

  // IDLE -> ACK (one cycle) -> GAP (one cycle) -> IDLE
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_GAP  = 2'd2
  } bus_state_t;

endpackage

// File: rtl/bq_sync_fifo.sv
// Synchronous FIFO holding queued samples; push and pop may coincide, flush
// empties it in one cycle and wins over a simultaneous push or pop.
module bq_sync_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_q[AW-1:0]] <= din;
  end

  assign head  = mem[rptr_q[AW-1:0]];
  assign level = wptr_q - rptr_q;
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

endmodule

// File: rtl/bq_sample_feeder.sv
// Wishbone-fed sample FIFO that paces samples into a biquad x input.
// Optional FIFO-empty interrupt with mask bit: define BQ_FEEDER_IRQ_EN.
module bq_sample_feeder
  import bq_pkg::*;
#(
  parameter int DW    = BQ_DW,
  parameter int DEPTH = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic          wb_ack_o,
  output logic [31:0]   wb_dat_o,
  output logic [DW-1:0] x,
  output logic          x_valid,
  output logic          irq_o,
  output bus_state_t    bus_state
);

  localparam int LW = $clog2(DEPTH) + 1;

  // Handshake: wb_ack_o is high for exactly the BUS_ACK cycle, and every
  // register side effect is applied on the clock edge that ends that cycle.
  bus_state_t state_q, state_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (wb_cyc_i && wb_stb_i) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_GAP;
      BUS_GAP:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  assign bus_state = state_q;
  assign wb_ack_o  = (state_q == BUS_ACK);

  logic [1:0] reg_sel;
  logic       wr, data_wr, ctrl_wr, stat_wr, flush;
  assign reg_sel = wb_adr_i[3:2];
  assign wr      = wb_ack_o && wb_cyc_i && wb_stb_i && wb_we_i;
  assign data_wr = wr && (reg_sel == REG_DATA);
  assign ctrl_wr = wr && (reg_sel == REG_CTRL);
  assign stat_wr = wr && (reg_sel == REG_STATUS);
  assign flush   = ctrl_wr && wb_dat_i[CTRL_FLUSH];

  logic        en_q;
  logic [15:0] div_q;
`ifdef BQ_FEEDER_IRQ_EN
  logic        mask_q;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_q   <= 1'b0;
      div_q  <= '0;
`ifdef BQ_FEEDER_IRQ_EN
      mask_q <= 1'b0;
`endif
    end else if (ctrl_wr) begin
      en_q   <= wb_dat_i[CTRL_EN];
      div_q  <= wb_dat_i[CTRL_DIV_LSB +: 16];
`ifdef BQ_FEEDER_IRQ_EN
      mask_q <= wb_dat_i[CTRL_MASK];
`endif
    end
  end

  // Counter is held at 0 while disabled so enabling always restarts the period.
  logic [15:0] cnt_q;
  logic        tick;
  assign tick = en_q && (cnt_q >= div_q);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)            cnt_q <= '0;
    else if (!en_q || tick)  cnt_q <= '0;
    else                     cnt_q <= cnt_q + 16'd1;
  end

  logic [DW-1:0] head;
  logic          fifo_full, fifo_empty, pop, push;
  logic [LW-1:0] level;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop  = tick && !fifo_empty && !flush;
  assign push = data_wr && (!fifo_full || pop);

  bq_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wb_dat_i[DW-1:0]),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  logic ovf_q, udf_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (stat_wr && wb_dat_i[STAT_OVF]) ovf_q <= 1'b0;
      if (stat_wr && wb_dat_i[STAT_UDF]) udf_q <= 1'b0;
      if (data_wr && fifo_full && !pop)  ovf_q <= 1'b1;
      if (tick && fifo_empty)            udf_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x       <= '0;
      x_valid <= 1'b0;
    end else begin
      x_valid <= pop;
      if (pop) x <= head;
    end
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]              = en_q;
        rdata[CTRL_DIV_LSB +: 16]   = div_q;
`ifdef BQ_FEEDER_IRQ_EN
        rdata[CTRL_MASK]            = mask_q;
`endif
      end
      REG_STATUS: begin
        rdata[STAT_EMPTY]           = fifo_empty;
        rdata[STAT_FULL]            = fifo_full;
        rdata[STAT_OVF]             = ovf_q;
        rdata[STAT_UDF]             = udf_q;
        rdata[STAT_LVL_LSB +: 8]    = 8'(level);
      end
      default: rdata = '0;
    endcase
  end

  assign wb_dat_o = (wb_ack_o && !wb_we_i) ? rdata : 32'h0;

`ifdef BQ_FEEDER_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= en_q && fifo_empty && !mask_q;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

endmodule
